// File: rtl/ysyx_24110006_axi_sram.sv
// rtl/ysyx_24110006_axi_sram.sv - AXI4 burst slave memory with fixed read latency and SLVERR window check
module ysyx_24110006_axi_sram #(
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter int          DEPTH  = 4096,
    parameter int          RD_LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic [3:0]  rid
);
    localparam int         AW        = $clog2(DEPTH);
    localparam logic [7:0] WAIT_LAST = 8'((RD_LAT > 1) ? (RD_LAT - 2) : 0);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLV  = 2'b10;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   addr_q;
    logic [3:0]    id_q;
    logic [7:0]    len_q;
    logic [7:0]    beat_q;
    logic [7:0]    wait_q;
    logic          range_ok_q;
    logic          wlast_err_q;
    logic [31:0]   beat_addr;
    logic [AW-1:0] word_idx;
    logic          last_beat;
    logic          ar_fire;
    logic          aw_fire;
    logic          w_fire;
    logic          r_fire;
    logic          b_fire;

    logic [31:0] mem [0:DEPTH-1];

    // The whole burst must fit in the window; 34-bit math keeps the end address from wrapping.
    function automatic logic in_window(input logic [31:0] start, input logic [7:0] len);
        logic [33:0] burst_end;
        logic [33:0] limit;
        burst_end = {2'b00, start} + (({26'd0, len} + 34'd1) << 2);
        limit     = {2'b00, BASE} + (34'(DEPTH) << 2);
        return (start >= BASE) && (burst_end <= limit);
    endfunction

    assign ar_fire   = arvalid && arready;
    assign aw_fire   = awvalid && awready;
    assign w_fire    = wvalid && wready;
    assign r_fire    = rvalid && rready;
    assign b_fire    = bvalid && bready;
    assign last_beat = (beat_q == len_q);
    assign beat_addr = addr_q + {22'd0, beat_q, 2'b00};
    assign word_idx  = AW'((beat_addr - BASE) >> 2);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a single transaction is in flight and reads win over writes in IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ar_fire) begin
                    state_next = (RD_LAT > 1) ? RD_WAIT : RD_DATA;
                end else if (aw_fire) begin
                    state_next = WR_DATA;
                end
            end
            RD_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_fire && last_beat) begin
                    state_next = IDLE;
                end
            end
            WR_DATA: begin
                if (w_fire && last_beat) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Transaction context: captured at the address handshake, beat/latency counters advance afterwards
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q      <= 32'd0;
            id_q        <= 4'd0;
            len_q       <= 8'd0;
            beat_q      <= 8'd0;
            wait_q      <= 8'd0;
            range_ok_q  <= 1'b0;
            wlast_err_q <= 1'b0;
        end else if (ar_fire) begin
            addr_q      <= araddr;
            id_q        <= arid;
            len_q       <= arlen;
            beat_q      <= 8'd0;
            wait_q      <= 8'd0;
            range_ok_q  <= in_window(araddr, arlen);
            wlast_err_q <= 1'b0;
        end else if (aw_fire) begin
            addr_q      <= awaddr;
            id_q        <= awid;
            len_q       <= awlen;
            beat_q      <= 8'd0;
            wait_q      <= 8'd0;
            range_ok_q  <= in_window(awaddr, awlen);
            wlast_err_q <= 1'b0;
        end else begin
            if (state == RD_WAIT) begin
                wait_q <= wait_q + 8'd1;
            end
            if (r_fire || w_fire) begin
                beat_q <= beat_q + 8'd1;
            end
            if (w_fire && (wlast != last_beat)) begin
                wlast_err_q <= 1'b1;
            end
        end
    end

    // Byte-masked memory write; contents are deliberately never reset
    always_ff @(posedge clock) begin
        if (!reset && w_fire && range_ok_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Outputs decoded from state and registered context only; data fields are zero outside their phase
    always_comb begin
        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = RESP_OKAY;
        bid     = 4'd0;
        rvalid  = 1'b0;
        rdata   = 32'd0;
        rresp   = RESP_OKAY;
        rlast   = 1'b0;
        rid     = 4'd0;
        case (state)
            IDLE: begin
                arready = 1'b1;
                awready = !arvalid;
            end
            RD_DATA: begin
                rvalid = 1'b1;
                rlast  = last_beat;
                rid    = id_q;
                rresp  = range_ok_q ? RESP_OKAY : RESP_SLV;
                rdata  = range_ok_q ? mem[word_idx] : 32'd0;
            end
            WR_DATA: begin
                wready = 1'b1;
            end
            WR_RESP: begin
                bvalid = 1'b1;
                bid    = id_q;
                bresp  = (range_ok_q && !wlast_err_q) ? RESP_OKAY : RESP_SLV;
            end
            default: ;
        endcase
    end
endmodule
